oj_compare_monitor: RTL and testbench
=====================================

Name: oj_compare_monitor

Overview:
- Downstream consumer of the judge bench's per-cycle output comparison. It takes the reference-model output and the user-module output, compares them on every enabled clock, and accumulates sample and mismatch counts.
- It records the index of the first failing sample and issues a registered pass/fail verdict when the test ends.
- It replaces the bare combinational mismatch wire with a synthesizable scoreboard, so a bench or on-board harness can report one result.

Parameters:
- DATA_W, 1, width of the compared outputs.
- CNT_W, 16, width of the sample counter, the mismatch counter and the first-error index.
- MAX_ERR, 0, mismatch count that aborts the run early; 0 disables early abort.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst  input  1  reset; asynchronous, active-high.
- start  input  1  one-cycle pulse; begins a new judging run.
- sample_en  input  1  compare window; a sample is taken only when this is high.
- ref_out  input  DATA_W  reference-model output.
- dut_out  input  DATA_W  user-module output.
- done  input  1  end-of-test pulse.
- busy  output  1  high while in RUN.
- sample_cnt  output  CNT_W  number of samples taken.
- mismatch_cnt  output  CNT_W  number of samples where ref_out != dut_out.
- first_err_idx  output  CNT_W  0-based index of the first mismatching sample.
- first_err_valid  output  1  first_err_idx holds a captured value.
- verdict_valid  output  1  verdict is final.
- pass  output  1  verdict is pass; meaningful only while verdict_valid is high.
- fail  output  1  verdict is fail; meaningful only while verdict_valid is high.

Behaviour:
- Clock and reset: one clock (clk). Reset is asynchronous and active-high (rst).
- Reset state: state IDLE. Every output is 0, including all counters, first_err_idx and the flags.
- States: IDLE, RUN, DONE. Encoding is free.
- IDLE:
  - start=1 -> RUN. On that edge, clear sample_cnt, mismatch_cnt, first_err_idx, first_err_valid, verdict_valid, pass and fail.
  - done, sample_en and the compare inputs are ignored.
- RUN:
  - busy=1.
  - On each edge with sample_en=1:
    - sample_cnt increments.
    - If ref_out != dut_out (full DATA_W compare): mismatch_cnt increments.
    - If that mismatch arrives while first_err_valid=0: first_err_idx loads the pre-increment sample_cnt and first_err_valid goes to 1.
  - Latency: all counters and flags are registered and reflect a sample one cycle after the edge that took it.
  - start=1 in RUN is ignored.
- Leaving RUN:
  - done=1 -> DONE. A sample taken on the same edge as done is counted.
  - If MAX_ERR != 0 and the updated mismatch_cnt equals MAX_ERR on this edge -> DONE (abort). This can coincide with done; the result is the same.
- DONE:
  - busy=0 and verdict_valid=1.
  - pass=1 only if mismatch_cnt==0 and sample_cnt!=0; fail=!pass. A run with zero samples is a fail.
  - Counters, flags and verdict hold until start.
  - start=1 in DONE -> RUN with the same clearing as from IDLE.
- Saturation: sample_cnt and mismatch_cnt saturate at all-ones and never wrap. A saturated sample_cnt still allows first_err_idx to capture the all-ones value.
- rst asserted mid-run: outputs clear immediately, with no clock required. Release returns to IDLE; no verdict is produced.
- Compare semantics: the compare is pure 2-state !=, so X/Z handling is outside this block.

Test Plan:
- Matching run: reset, start, 8 cycles of sample_en=1 with ref_out==dut_out, then done -> sample_cnt=8, mismatch_cnt=0, first_err_valid=0, verdict_valid=1, pass=1, fail=0.
- Mismatches: in a 10-sample run, dut_out differs on samples 3 and 7 (0-based) -> mismatch_cnt=2, first_err_idx=3, first_err_valid=1, fail=1.
- Early abort: MAX_ERR=2, every sample mismatching -> DONE one edge after the 2nd sample, with sample_cnt=2, mismatch_cnt=2 and fail=1. Later done and sample_en have no effect.
- Empty run and gated samples:
  - start then done with sample_en=0 throughout -> sample_cnt=0, fail=1.
  - Mismatches while sample_en=0 -> not counted.
- Boundaries:
  - done on the same edge as a mismatching sample -> that sample is counted and the verdict is fail.
  - CNT_W=3 with 10 matching samples -> sample_cnt=7 (saturated), pass=1.
- Reset and restart:
  - rst pulse mid-RUN, checked between clock edges -> all outputs 0.
  - A new start after the reset runs cleanly.
  - start issued in DONE clears the previous verdict one cycle later.

Source files
------------

// File: rtl/oj_compare_monitor_if.sv
// rtl/oj_compare_monitor_if.sv - Stimulus/result bundle between a judge harness and the compare monitor
interface oj_compare_monitor_if #(
  parameter int DATA_W = 1,
  parameter int CNT_W  = 16
);
  logic              start;
  logic              sample_en;
  logic [DATA_W-1:0] ref_out;
  logic [DATA_W-1:0] dut_out;
  logic              done;
  logic              busy;
  logic [CNT_W-1:0]  sample_cnt;
  logic [CNT_W-1:0]  mismatch_cnt;
  logic [CNT_W-1:0]  first_err_idx;
  logic              first_err_valid;
  logic              verdict_valid;
  logic              pass;
  logic              fail;

  modport master (
    output start, sample_en, ref_out, dut_out, done,
    input  busy, sample_cnt, mismatch_cnt, first_err_idx, first_err_valid,
           verdict_valid, pass, fail
  );

  modport slave (
    input  start, sample_en, ref_out, dut_out, done,
    output busy, sample_cnt, mismatch_cnt, first_err_idx, first_err_valid,
           verdict_valid, pass, fail
  );
endinterface

// File: rtl/oj_compare_monitor.sv
// rtl/oj_compare_monitor.sv - Judge-bench output compare scoreboard with registered pass/fail verdict
// Counts samples and mismatches per run, latches the first failing index, optionally aborts early.
module oj_compare_monitor #(
  parameter int DATA_W  = 1,
  parameter int CNT_W   = 16,
  parameter int MAX_ERR = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  oj_compare_monitor_if.slave  mon
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [CNT_W-1:0] MAX_ERR_C = CNT_W'(MAX_ERR);
  localparam bit               ABORT_EN  = (MAX_ERR != 0);

  state_t            state_q;
  logic [CNT_W-1:0]  sample_cnt_q;
  logic [CNT_W-1:0]  mismatch_cnt_q;
  logic [CNT_W-1:0]  first_err_idx_q;
  logic              first_err_valid_q;
  logic              busy_q;
  logic              verdict_valid_q;
  logic              pass_q;
  logic              fail_q;

  logic [DATA_W-1:0] ref_w;
  logic [DATA_W-1:0] dut_w;
  logic              take;
  logic              miss;
  logic              abort;
  logic              finish;
  logic              pass_d;
  logic [CNT_W-1:0]  sample_cnt_d;
  logic [CNT_W-1:0]  mismatch_cnt_d;

  assign ref_w = mon.ref_out;
  assign dut_w = mon.dut_out;

  always_comb begin
    take           = (state_q == S_RUN) && mon.sample_en;
    miss           = take && (ref_w != dut_w);
    sample_cnt_d   = sample_cnt_q;
    mismatch_cnt_d = mismatch_cnt_q;
    if (take && (sample_cnt_q != CNT_MAX)) begin
      sample_cnt_d = sample_cnt_q + 1'b1;
    end
    if (miss && (mismatch_cnt_q != CNT_MAX)) begin
      mismatch_cnt_d = mismatch_cnt_q + 1'b1;
    end
    // Abort is judged on the post-update count so the MAX_ERR-th mismatch ends the run.
    abort  = ABORT_EN && miss && (mismatch_cnt_d == MAX_ERR_C);
    finish = (state_q == S_RUN) && (mon.done || abort);
    pass_d = (mismatch_cnt_d == '0) && (sample_cnt_d != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q           <= S_IDLE;
      sample_cnt_q      <= '0;
      mismatch_cnt_q    <= '0;
      first_err_idx_q   <= '0;
      first_err_valid_q <= 1'b0;
      busy_q            <= 1'b0;
      verdict_valid_q   <= 1'b0;
      pass_q            <= 1'b0;
      fail_q            <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (mon.start) begin
            state_q           <= S_RUN;
            sample_cnt_q      <= '0;
            mismatch_cnt_q    <= '0;
            first_err_idx_q   <= '0;
            first_err_valid_q <= 1'b0;
            busy_q            <= 1'b1;
            verdict_valid_q   <= 1'b0;
            pass_q            <= 1'b0;
            fail_q            <= 1'b0;
          end
        end
        S_RUN: begin
          sample_cnt_q   <= sample_cnt_d;
          mismatch_cnt_q <= mismatch_cnt_d;
          // Pre-increment count is the 0-based index, including the saturated value.
          if (miss && !first_err_valid_q) begin
            first_err_idx_q   <= sample_cnt_q;
            first_err_valid_q <= 1'b1;
          end
          if (finish) begin
            state_q         <= S_DONE;
            busy_q          <= 1'b0;
            verdict_valid_q <= 1'b1;
            pass_q          <= pass_d;
            fail_q          <= !pass_d;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mon.busy            = busy_q;
  assign mon.sample_cnt      = sample_cnt_q;
  assign mon.mismatch_cnt    = mismatch_cnt_q;
  assign mon.first_err_idx   = first_err_idx_q;
  assign mon.first_err_valid = first_err_valid_q;
  assign mon.verdict_valid   = verdict_valid_q;
  assign mon.pass            = pass_q;
  assign mon.fail            = fail_q;

endmodule

// File: tb/tb_oj_compare_monitor.sv
// tb/tb_oj_compare_monitor.sv - Directed scoreboard bench for oj_compare_monitor
module tb_oj_compare_monitor;

  logic clk;
  logic rst;

  oj_compare_monitor_if #(.DATA_W(4), .CNT_W(16)) ifa ();
  oj_compare_monitor_if #(.DATA_W(4), .CNT_W(16)) ifb ();
  oj_compare_monitor_if #(.DATA_W(4), .CNT_W(3))  ifc ();

  oj_compare_monitor #(.DATA_W(4), .CNT_W(16), .MAX_ERR(0)) u_main  (.clk(clk), .rst(rst), .mon(ifa));
  oj_compare_monitor #(.DATA_W(4), .CNT_W(16), .MAX_ERR(2)) u_abort (.clk(clk), .rst(rst), .mon(ifb));
  oj_compare_monitor #(.DATA_W(4), .CNT_W(3),  .MAX_ERR(0)) u_sat   (.clk(clk), .rst(rst), .mon(ifc));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] sc;
    logic [15:0] mc;
    logic [15:0] fi;
    logic        fv;
    logic        ps;
    logic        fl;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  logic [3:0] s_ref[32];
  logic [3:0] s_dut[32];
  bit         s_en[32];
  int         s_n;
  bit         s_done_last;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic pop_cmp(input string tag, input logic [15:0] sc, input logic [15:0] mc,
                         input logic [15:0] fi, input logic fv, input logic vv,
                         input logic ps, input logic fl);
    exp_t e;
    checks++;
    assert (exp_q.size() != 0) else begin
      failures++;
      $error("FAIL %s scoreboard_empty observed=0 expected=1", tag);
    end
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check({tag, ".verdict_valid"},   32'(vv), 32'd1);
    check({tag, ".sample_cnt"},      32'(sc), 32'(e.sc));
    check({tag, ".mismatch_cnt"},    32'(mc), 32'(e.mc));
    check({tag, ".first_err_idx"},   32'(fi), 32'(e.fi));
    check({tag, ".first_err_valid"}, 32'(fv), 32'(e.fv));
    check({tag, ".pass"},            32'(ps), 32'(e.ps));
    check({tag, ".fail"},            32'(fl), 32'(e.fl));
  endtask

  task automatic wait_vv_a(input string tag);
    int k = 0;
    while (!ifa.verdict_valid && k < 20) begin
      tick();
      k++;
    end
    check({tag, ".verdict_timeout"}, 32'(ifa.verdict_valid), 32'd1);
    check({tag, ".busy"}, 32'(ifa.busy), 32'd0);
    pop_cmp(tag, ifa.sample_cnt, ifa.mismatch_cnt, ifa.first_err_idx,
            ifa.first_err_valid, ifa.verdict_valid, ifa.pass, ifa.fail);
  endtask

  task automatic run_main(input string tag);
    exp_t e;
    e = '{sc: 16'd0, mc: 16'd0, fi: 16'd0, fv: 1'b0, ps: 1'b0, fl: 1'b0};
    for (int i = 0; i < s_n; i++) begin
      if (s_en[i]) begin
        if (s_ref[i] != s_dut[i]) begin
          if (!e.fv) begin
            e.fi = e.sc;
            e.fv = 1'b1;
          end
          e.mc++;
        end
        e.sc++;
      end
    end
    e.ps = (e.mc == 0) && (e.sc != 0);
    e.fl = !e.ps;
    exp_q.push_back(e);
    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    for (int i = 0; i < s_n; i++) begin
      ifa.sample_en = s_en[i];
      ifa.ref_out   = s_ref[i];
      ifa.dut_out   = s_dut[i];
      ifa.done      = s_done_last && (i == s_n - 1);
      tick();
    end
    ifa.sample_en = 1'b0;
    ifa.ref_out   = 4'd0;
    ifa.dut_out   = 4'd0;
    if (!(s_done_last && s_n > 0)) begin
      ifa.done = 1'b1;
      tick();
    end
    ifa.done = 1'b0;
    wait_vv_a(tag);
  endtask

  initial begin
    exp_t e;
    int   k;
    rst = 1'b1;
    ifa.start = 0; ifa.sample_en = 0; ifa.ref_out = 0; ifa.dut_out = 0; ifa.done = 0;
    ifb.start = 0; ifb.sample_en = 0; ifb.ref_out = 0; ifb.dut_out = 0; ifb.done = 0;
    ifc.start = 0; ifc.sample_en = 0; ifc.ref_out = 0; ifc.dut_out = 0; ifc.done = 0;
    tick();
    tick();

    check("rst.busy",            32'(ifa.busy), 32'd0);
    check("rst.sample_cnt",      32'(ifa.sample_cnt), 32'd0);
    check("rst.mismatch_cnt",    32'(ifa.mismatch_cnt), 32'd0);
    check("rst.first_err_idx",   32'(ifa.first_err_idx), 32'd0);
    check("rst.first_err_valid", 32'(ifa.first_err_valid), 32'd0);
    check("rst.verdict_valid",   32'(ifa.verdict_valid), 32'd0);
    check("rst.pass",            32'(ifa.pass), 32'd0);
    check("rst.fail",            32'(ifa.fail), 32'd0);
    check("rst.abort_vv",        32'(ifb.verdict_valid), 32'd0);
    check("rst.sat_sample_cnt",  32'(ifc.sample_cnt), 32'd0);
    rst = 1'b0;
    tick();

    ifa.done = 1'b1; ifa.sample_en = 1'b1; ifa.ref_out = 4'd1;
    tick();
    ifa.done = 1'b0; ifa.sample_en = 1'b0; ifa.ref_out = 4'd0;
    tick();
    check("idle.sample_cnt",    32'(ifa.sample_cnt), 32'd0);
    check("idle.verdict_valid", 32'(ifa.verdict_valid), 32'd0);
    check("idle.busy",          32'(ifa.busy), 32'd0);

    s_n = 8; s_done_last = 0;
    for (int i = 0; i < 8; i++) begin
      s_en[i] = 1; s_ref[i] = 4'(i); s_dut[i] = 4'(i);
    end
    run_main("match");

    s_n = 10; s_done_last = 0;
    for (int i = 0; i < 10; i++) begin
      s_en[i] = 1; s_ref[i] = 4'(i + 1);
      s_dut[i] = (i == 3 || i == 7) ? ~4'(i + 1) : 4'(i + 1);
    end
    run_main("mismatch");

    s_n = 0; s_done_last = 0;
    run_main("empty");

    s_n = 6; s_done_last = 0;
    for (int i = 0; i < 6; i++) begin
      s_en[i] = (i % 2 == 0); s_ref[i] = 4'd5;
      s_dut[i] = (i % 2 == 0) ? 4'd5 : 4'd9;
    end
    run_main("gated");

    s_n = 4; s_done_last = 1;
    for (int i = 0; i < 4; i++) begin
      s_en[i] = 1; s_ref[i] = 4'd3; s_dut[i] = (i == 3) ? 4'd4 : 4'd3;
    end
    run_main("done_on_miss");

    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    check("restart.verdict_valid",   32'(ifa.verdict_valid), 32'd0);
    check("restart.fail",            32'(ifa.fail), 32'd0);
    check("restart.pass",            32'(ifa.pass), 32'd0);
    check("restart.mismatch_cnt",    32'(ifa.mismatch_cnt), 32'd0);
    check("restart.first_err_valid", 32'(ifa.first_err_valid), 32'd0);
    check("restart.busy",            32'(ifa.busy), 32'd1);
    exp_q.push_back('{sc: 16'd0, mc: 16'd0, fi: 16'd0, fv: 1'b0, ps: 1'b0, fl: 1'b1});
    ifa.done = 1'b1;
    tick();
    ifa.done = 1'b0;
    wait_vv_a("restart_empty");

    ifa.start = 1'b1;
    tick();
    ifa.start = 1'b0;
    ifa.sample_en = 1'b1; ifa.ref_out = 4'd1; ifa.dut_out = 4'd2;
    tick();
    tick();
    #2 rst = 1'b1;
    #1;
    check("midrst.busy",            32'(ifa.busy), 32'd0);
    check("midrst.sample_cnt",      32'(ifa.sample_cnt), 32'd0);
    check("midrst.mismatch_cnt",    32'(ifa.mismatch_cnt), 32'd0);
    check("midrst.first_err_valid", 32'(ifa.first_err_valid), 32'd0);
    check("midrst.first_err_idx",   32'(ifa.first_err_idx), 32'd0);
    check("midrst.verdict_valid",   32'(ifa.verdict_valid), 32'd0);
    tick();
    rst = 1'b0;
    ifa.sample_en = 1'b0; ifa.ref_out = 4'd0; ifa.dut_out = 4'd0;
    ifa.done = 1'b1;
    tick();
    ifa.done = 1'b0;
    check("postrst.verdict_valid", 32'(ifa.verdict_valid), 32'd0);
    check("postrst.busy",          32'(ifa.busy), 32'd0);

    s_n = 5; s_done_last = 0;
    for (int i = 0; i < 5; i++) begin
      s_en[i] = 1; s_ref[i] = 4'(i + 7); s_dut[i] = 4'(i + 7);
    end
    run_main("after_rst");

    e = '{sc: 16'd0, mc: 16'd0, fi: 16'd0, fv: 1'b0, ps: 1'b0, fl: 1'b0};
    for (int i = 0; i < 5; i++) begin
      if (!e.fv) begin
        e.fi = e.sc;
        e.fv = 1'b1;
      end
      e.sc++;
      e.mc++;
      if (e.mc == 2) break;
    end
    e.ps = (e.mc == 0) && (e.sc != 0);
    e.fl = !e.ps;
    exp_q.push_back(e);
    ifb.start = 1'b1;
    tick();
    ifb.start = 1'b0;
    ifb.sample_en = 1'b1; ifb.ref_out = 4'd6; ifb.dut_out = 4'd1;
    tick();
    check("abort.busy_after_1", 32'(ifb.busy), 32'd1);
    tick();
    check("abort.busy_after_2", 32'(ifb.busy), 32'd0);
    pop_cmp("abort", ifb.sample_cnt, ifb.mismatch_cnt, ifb.first_err_idx,
            ifb.first_err_valid, ifb.verdict_valid, ifb.pass, ifb.fail);
    tick();
    tick();
    ifb.done = 1'b1;
    tick();
    ifb.done = 1'b0; ifb.sample_en = 1'b0;
    tick();
    check("abort_hold.sample_cnt",   32'(ifb.sample_cnt), 32'd2);
    check("abort_hold.mismatch_cnt", 32'(ifb.mismatch_cnt), 32'd2);
    check("abort_hold.fail",         32'(ifb.fail), 32'd1);

    exp_q.push_back('{sc: 16'd7, mc: 16'd0, fi: 16'd0, fv: 1'b0, ps: 1'b1, fl: 1'b0});
    ifc.start = 1'b1;
    tick();
    ifc.start = 1'b0;
    for (int i = 0; i < 10; i++) begin
      ifc.sample_en = 1'b1; ifc.ref_out = 4'(i); ifc.dut_out = 4'(i);
      tick();
    end
    ifc.sample_en = 1'b0;
    ifc.done = 1'b1;
    tick();
    ifc.done = 1'b0;
    k = 0;
    while (!ifc.verdict_valid && k < 20) begin
      tick();
      k++;
    end
    check("sat.verdict_timeout", 32'(ifc.verdict_valid), 32'd1);
    pop_cmp("sat", 16'(ifc.sample_cnt), 16'(ifc.mismatch_cnt), 16'(ifc.first_err_idx),
            ifc.first_err_valid, ifc.verdict_valid, ifc.pass, ifc.fail);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
